// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================
// cpu_pkg : shared widths and types for the CPU register path
// Revision: 1.0
// ============================================================
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int SEL_W    = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  reg_sel_t;

endpackage
`default_nettype wire

// File: rtl/mux_sel_comb.sv
`default_nettype none
// ============================================================
// mux_sel_comb : combinational 16:1 register-bank word selector
// Revision: 1.0
// ============================================================
module mux_sel_comb
  import cpu_pkg::*;
(
  input  reg_sel_t sel,
  input  word_t    r0,
  input  word_t    r1,
  input  word_t    r2,
  input  word_t    r3,
  input  word_t    r4,
  input  word_t    r5,
  input  word_t    r6,
  input  word_t    r7,
  input  word_t    r8,
  input  word_t    r9,
  input  word_t    r10,
  input  word_t    r11,
  input  word_t    r12,
  input  word_t    r13,
  input  word_t    r14,
  input  word_t    r15,
  output word_t    word
);

  always_comb begin
    word = 'x;
    case (sel)
      4'd0:    word = r0;
      4'd1:    word = r1;
      4'd2:    word = r2;
      4'd3:    word = r3;
      4'd4:    word = r4;
      4'd5:    word = r5;
      4'd6:    word = r6;
      4'd7:    word = r7;
      4'd8:    word = r8;
      4'd9:    word = r9;
      4'd10:   word = r10;
      4'd11:   word = r11;
      4'd12:   word = r12;
      4'd13:   word = r13;
      4'd14:   word = r14;
      4'd15:   word = r15;
      // Only an X/Z select lands here; leaves the word unknown in simulation.
      default: word = 'x;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================
// mux : registered register-bank read multiplexer (1-cycle latency)
// Revision: 1.0
// ============================================================
module mux
  import cpu_pkg::*;
(
  input  logic     Clock,
  output word_t    Output,
  input  reg_sel_t Select,
  input  word_t    r0,
  input  word_t    r1,
  input  word_t    r2,
  input  word_t    r3,
  input  word_t    r4,
  input  word_t    r5,
  input  word_t    r6,
  input  word_t    r7,
  input  word_t    r8,
  input  word_t    r9,
  input  word_t    r10,
  input  word_t    r11,
  input  word_t    r12,
  input  word_t    r13,
  input  word_t    r14,
  input  word_t    r15,
  input  logic     Reset
);

  word_t w_sel_word;

  mux_sel_comb u_sel (
    .sel  (Select),
    .r0   (r0),
    .r1   (r1),
    .r2   (r2),
    .r3   (r3),
    .r4   (r4),
    .r5   (r5),
    .r6   (r6),
    .r7   (r7),
    .r8   (r8),
    .r9   (r9),
    .r10  (r10),
    .r11  (r11),
    .r12  (r12),
    .r13  (r13),
    .r14  (r14),
    .r15  (r15),
    .word (w_sel_word)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Output <= '0;
    end else begin
      Output <= w_sel_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux.sv
`default_nettype none
// ============================================================
// tb_mux : directed self-checking bench for the register-bank mux
// Revision: 1.0
// ============================================================
module tb_mux;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Select;
  logic [31:0] r [16];
  logic [31:0] Output;

  int total = 0;
  int bad   = 0;

  mux dut (
    .Clock  (Clock),
    .Output (Output),
    .Select (Select),
    .r0     (r[0]),
    .r1     (r[1]),
    .r2     (r[2]),
    .r3     (r[3]),
    .r4     (r[4]),
    .r5     (r[5]),
    .r6     (r[6]),
    .r7     (r[7]),
    .r8     (r[8]),
    .r9     (r[9]),
    .r10    (r[10]),
    .r11    (r[11]),
    .r12    (r[12]),
    .r13    (r[13]),
    .r14    (r[14]),
    .r15    (r[15]),
    .Reset  (Reset)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset  = 1'b0;
    Select = 4'd0;
    for (int i = 0; i < 16; i++) r[i] = 32'h0;
    r[0] = 32'h1234_5678;

    // Held in reset: output stays zero across edges
    #1;
    chk("reset_pre_edge", Output, 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      chk("reset_hold", Output, 32'h0);
    end

    @(negedge Clock);
    Reset = 1'b1;
    edge_sample();
    chk("reset_release", Output, 32'h1234_5678);

    // One-cycle latency
    Select = 4'd1;
    r[1]   = 32'h0AAA_AAAA;
    #3;
    chk("latency_not_before", Output, 32'h1234_5678);
    edge_sample();
    chk("latency_after_edge", Output, 32'd178956970);

    // Full sweep
    for (int i = 0; i < 16; i++) r[i] = 32'hA000_0000 + 32'(i);
    for (int s = 0; s < 16; s++) begin
      Select = 4'(s);
      edge_sample();
      chk($sformatf("sweep_sel%0d", s), Output, 32'hA000_0000 + 32'(s));
    end

    // Register change with Select held
    Select = 4'd7;
    r[7]   = 32'hFFFF_FFFF;
    edge_sample();
    chk("hold_sel7_initial", Output, 32'hFFFF_FFFF);
    #2;
    r[7] = 32'h0000_0001;
    r[6] = 32'h0BAD_0006;
    #1;
    chk("hold_sel7_midcycle", Output, 32'hFFFF_FFFF);
    edge_sample();
    chk("hold_sel7_updated", Output, 32'h0000_0001);
    r[6] = 32'h1357_9BDF;
    edge_sample();
    chk("r6_no_effect", Output, 32'h0000_0001);

    // Asynchronous reset between edges
    Select = 4'd2;
    r[2]   = 32'hDEAD_BEEF;
    edge_sample();
    chk("async_pre", Output, 32'hDEAD_BEEF);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_clear", Output, 32'h0);
    @(negedge Clock);
    chk("async_hold", Output, 32'h0);
    Reset = 1'b1;
    edge_sample();
    chk("async_release", Output, 32'hDEAD_BEEF);

    // Simultaneous Select and register change
    Select = 4'd3;
    r[3]   = 32'h3333_3333;
    edge_sample();
    chk("simul_sel3", Output, 32'h3333_3333);
    Select = 4'd12;
    r[12]  = 32'h5555_5555;
    edge_sample();
    chk("simul_sel12", Output, 32'h5555_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux.md
Name: mux

Overview:
- Register-bank read multiplexer for the master CPU.
- Selects one of sixteen 32-bit register values (r0..r15) using a 4-bit Select.
- Presents the selected value on a registered Output, updated on the rising edge of Clock.
- Feeds the register-bank read path toward the datapath.

Parameters:
- DATA_W, 32, width of each register input and of Output.
- NUM_REGS, 16, number of register inputs; fixed at 16 (r0..r15 are explicit ports).
- SEL_W, 4, width of Select; must equal log2(NUM_REGS).

Ports:
- Clock  input  1  system clock; rising-edge active.
- Reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
- Output  output  DATA_W  registered selected register value.
- Select  input  SEL_W  register index 0..15.
- r0..r15  input  DATA_W each  register values; port order after Select is r0, r1, ..., r15.
- Positional order for instantiation: Clock, Output, Select, r0..r15, Reset.
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset assertion (Reset falls to 0) clears Output to 32'h0000_0000 immediately, independent of Clock.
- While Reset = 0, Output holds 0 and ignores Clock, Select and r0..r15.
- Reset release is synchronous in effect: the first update is on the first rising Clock edge where Reset = 1.
- On each rising Clock edge with Reset = 1: Output <= r[Select], where r[n] is port rn.
- Latency is exactly 1 clock. Select and rN are sampled together at the edge; changes between edges have no effect until the next edge.
- No combinational path from inputs to Output.
- Full 4-bit decode: every code 0..15 maps to exactly one register. No out-of-range case and no default-to-zero path is reachable.
- If Select contains X/Z in simulation, Output becomes X. Synthesis treats it as don't-care.
- An undriven or X register input propagates X to Output only when that register is selected.
- Select and a register value changing in the same inter-edge window: the edge captures the new Select with the new register value.
- No enable input: Output updates every cycle.
- Width rule: pure bit pass-through, no sign or zero extension, no arithmetic.

Decomposition:
- Shared package (cpu_pkg): constants DATA_W = 32, NUM_REGS = 16, SEL_W = 4.
- Shared package also holds typedef word_t (logic [DATA_W-1:0]) and typedef reg_sel_t (logic [SEL_W-1:0]).
- One natural sub-module, mux_sel_comb: purely combinational 16:1 selector (Select, r0..r15 -> selected word), implemented as a full case over all 16 codes.
- Top level mux: instantiates mux_sel_comb and adds the asynchronous-reset output register.

Test Plan:
- Reset: Reset = 0 with r0 = 32'h1234_5678, Select = 0, Clock toggling -> Output = 0 at every edge. Release Reset -> Output = 32'h1234_5678 after the first rising edge.
- Basic select with 1-cycle latency: Select = 1, r1 = 32'h0AAA_AAAA (178956970), applied just after an edge -> Output = 178956970 at the next rising edge and not before.
- Full sweep: load rN = 32'hA000_0000 + N and step Select 0..15, one per cycle -> Output = 32'hA000_0000 + (Select of the previous cycle) each edge. Covers 0 and 15 boundaries.
- Register change without select change: Select = 7 held, r7 changes 32'hFFFF_FFFF -> 32'h0000_0001 mid-cycle -> Output updates only at the following edge. Changing r6 has no effect on Output.
- Asynchronous reset mid-operation: Output = 32'hDEAD_BEEF, pull Reset low between edges -> Output = 0 within the same cycle, before any Clock edge.
- Simultaneous change: Select 3 -> 12 and r12 = 32'h5555_5555 in the same window -> next edge Output = 32'h5555_5555.
